clk_tick_gen: RTL and testbench

//   Multi-channel programmable clock-enable generator driven by the on-chip

---
 rtl/clk_tick_gen.sv | 80 ++++++++
 tb/tb_clk_tick_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// tick every (DIV+1) clocks plus a square wave that toggles on each tick.
module clk_tick_gen #(
  parameter int NCH     = 2,
  parameter int DIVW    = 16,
  parameter int DEF_DIV = 11,
  parameter int CHW     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  en,
  input  logic            restart,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [DIVW-1:0] wr_data,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  sq,
  output logic [NCH-1:0]  pend
);

  logic [DIVW-1:0] cnt   [NCH];
  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_p [NCH];
  logic [DIVW-1:0] dn    [NCH];
  logic [NCH-1:0]  hit;

  // Divisor for the next period: a same-cycle write bypasses the pending slot.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i] = wr_en && (wr_ch == CHW'(i));
      if (hit[i])
        dn[i] = wr_data;
      else if (pend[i])
        dn[i] = div_p[i];
      else
        dn[i] = div_q[i];
    end
  end

  // Down-counter reloads only at zero, so a new divisor never cuts a period short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        div_q[i] <= DIVW'(DEF_DIV);
        div_p[i] <= '0;
      end
      tick <= '0;
      sq   <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (restart) begin
          cnt[i]  <= '0;
          sq[i]   <= 1'b0;
          tick[i] <= 1'b0;
          if (hit[i]) begin
            div_p[i] <= wr_data;
            pend[i]  <= 1'b1;
          end
        end else if (en[i] && (cnt[i] == '0)) begin
          tick[i]  <= 1'b1;
          sq[i]    <= ~sq[i];
          cnt[i]   <= dn[i];
          div_q[i] <= dn[i];
          pend[i]  <= 1'b0;
        end else begin
          tick[i] <= 1'b0;
          if (en[i])
            cnt[i] <= cnt[i] - 1'b1;
          if (hit[i]) begin
            div_p[i] <= wr_data;
            pend[i]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: directed scenarios followed by random traffic,
// compared every cycle against an elapsed-cycle reference model.
module tb_clk_tick_gen;

  localparam int NCH     = 2;
  localparam int DIVW    = 16;
  localparam int DEF_DIV = 11;
  localparam int CHW     = 3;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            restart;
  logic            wr_en;
  logic [CHW-1:0]  wr_ch;
  logic [DIVW-1:0] wr_data;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  sq;
  logic [NCH-1:0]  pend;

  int n_cmp;
  int n_err;

  clk_tick_gen #(.NCH(NCH), .DIVW(DIVW), .DEF_DIV(DEF_DIV), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .tick(tick), .sq(sq), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a tick is due when the enabled cycles elapsed since the last
  // tick reach the active divisor, or right after reset/restart.
  int m_div   [NCH];
  int m_pdiv  [NCH];
  int m_since [NCH];
  bit m_pend  [NCH];
  bit m_due   [NCH];
  bit m_sq    [NCH];
  bit m_tick  [NCH];

  function automatic logic [NCH-1:0] pack(input bit v [NCH]);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEF_DIV; m_pdiv[i] = 0; m_since[i] = 0;
      m_pend[i] = 0; m_due[i] = 1; m_sq[i] = 0; m_tick[i] = 0;
    end
  endtask

  task automatic modelUpdate();
    bit h;
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      h = wr_en && (int'(wr_ch) == i);
      if (restart) begin
        m_due[i] = 1; m_since[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
        if (h) begin m_pdiv[i] = int'(wr_data); m_pend[i] = 1; end
      end else if (en[i] && (m_due[i] || m_since[i] == m_div[i])) begin
        m_div[i]   = h ? int'(wr_data) : (m_pend[i] ? m_pdiv[i] : m_div[i]);
        m_pend[i]  = 0; m_tick[i] = 1; m_sq[i] = ~m_sq[i];
        m_since[i] = 0; m_due[i] = 0;
      end else begin
        m_tick[i] = 0;
        if (en[i]) m_since[i]++;
        if (h) begin m_pdiv[i] = int'(wr_data); m_pend[i] = 1; end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] e, input logic r, input logic w,
                               input logic [CHW-1:0] ch, input logic [DIVW-1:0] d);
    en = e; restart = r; wr_en = w; wr_ch = ch; wr_data = d;
  endtask

  // One clock: model advances on the same edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("tick", 8'(tick), 8'(pack(m_tick)));
    checkOutput("sq",   8'(sq),   8'(pack(m_sq)));
    checkOutput("pend", 8'(pend), 8'(pack(m_pend)));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    modelReset();
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_tick", 8'(tick), 8'h00);
    checkOutput("reset_sq",   8'(sq),   8'h00);
    checkOutput("reset_pend", 8'(pend), 8'h00);

    $display("[TB] scenario 1: ch0 default divisor");
    rst_n = 1'b1;
    applyStimulus(2'b01, 1'b0, 1'b0, '0, '0);
    step();
    checkOutput("first_tick", 8'(tick), 8'h01);
    run(50);

    $display("[TB] scenario 2: mid-period divisor change");
    for (int k = 0; k < 20 && !m_tick[0]; k++) step();
    run(5);
    applyStimulus(2'b01, 1'b0, 1'b1, 3'd0, 16'd3);
    step();
    checkOutput("pend_after_write", 8'(pend), 8'h01);
    applyStimulus(2'b01, 1'b0, 1'b0, '0, '0);
    run(30);

    $display("[TB] scenario 3: bypass write of D=0 on ch1");
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd1, 16'd0);
    step();
    applyStimulus(2'b11, 1'b0, 1'b0, '0, '0);
    run(10);
    checkOutput("d0_tick_held", 8'(tick[1]), 8'h01);

    $display("[TB] scenario 4: enable gap on ch0");
    applyStimulus(2'b01, 1'b0, 1'b1, 3'd0, 16'd9);
    step();
    applyStimulus(2'b01, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 20 && !m_tick[0]; k++) step();
    run(5);
    applyStimulus(2'b00, 1'b0, 1'b0, '0, '0);
    run(5);
    applyStimulus(2'b01, 1'b0, 1'b0, '0, '0);
    run(25);

    $display("[TB] scenario 5: restart applies pending divisor");
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd0, 16'd7);
    step();
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd1, 16'd2);
    step();
    applyStimulus(2'b11, 1'b0, 1'b0, '0, '0);
    run(20);
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd1, 16'd5);
    step();
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    step();
    checkOutput("restart_clears", 8'(tick), 8'h00);
    applyStimulus(2'b11, 1'b0, 1'b0, '0, '0);
    step();
    checkOutput("restart_tick", 8'(tick), 8'h03);
    checkOutput("restart_sq",   8'(sq),   8'h03);
    run(30);

    $display("[TB] scenario 6: out-of-range write and async reset");
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd2, 16'd1);
    step();
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd7, 16'd1);
    step();
    checkOutput("bad_ch_pend", 8'(pend), 8'h00);
    applyStimulus(2'b11, 1'b0, 1'b1, 3'd0, 16'd4);
    step();
    applyStimulus(2'b11, 1'b0, 1'b0, '0, '0);
    run(3);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_tick", 8'(tick), 8'h00);
    checkOutput("async_sq",   8'(sq),   8'h00);
    checkOutput("async_pend", 8'(pend), 8'h00);
    run(2);
    rst_n = 1'b1;
    run(40);

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(NCH'($urandom_range(0, 3) != 0 ? 2'b11 : 2'(($urandom))),
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) == 0),
                    CHW'($urandom_range(0, 3)),
                    DIVW'($urandom_range(0, 12)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
